input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end conditioner for the board's raw KEY and SW pins, one per input bit.
//  Per bit: 2-flop synchroniser, counter debounce, clean level plus 1-cycle edge pulses.
//  Sits directly upstream of MyComputer, which consumes the clean levels and pulses
//  instead of the raw pins.
// PARAMETERS
//  N_KEY            4    number of push-buttons; raw buttons are active-low (0 = pressed)
//  N_SW             10   number of slide switches; raw switches are active-high
//  DEBOUNCE_CYCLES  4    consecutive clk edges an input must hold before it is accepted; >=2
//  CNT_W            8    debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk          in   1      system clock; single clock domain
//  resetn       in   1      synchronous active-low reset
//  KEY          in   N_KEY  raw asynchronous push-buttons, active-low
//  SW           in   N_SW   raw asynchronous slide switches
//  key_level    out  N_KEY  debounced button state, active-HIGH (1 = pressed)
//  key_press    out  N_KEY  1-cycle pulse when a button is accepted as pressed
//  key_release  out  N_KEY  1-cycle pulse when a button is accepted as released
//  sw_level     out  N_SW   debounced switch state
//  sw_change    out  N_SW   1-cycle pulse when a switch is accepted at a new value
// BEHAVIOUR
//  Reset (resetn=0 at a rising edge of clk)
//   - Synchroniser flops: KEY bits reset to 1, SW bits reset to 0.
//   - stable state: every button reads released, every switch reads 0.
//   - All counters reset to 0.
//   - All outputs reset to 0.
//   - Reset asserted mid-debounce discards the partial count.
//   - After reset, an input already held non-default is debounced normally,
//     then produces its press or change pulse.
//  Synchroniser: s1 <= raw; s2 <= s1. Only s2 is used downstream.
//  Debounce, per bit, at each clk edge, with stable = accepted value:
//   - s2 == stable: counter <= 0.
//   - s2 != stable and counter <  DEBOUNCE_CYCLES-1: counter <= counter+1.
//   - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2; counter <= 0.
//  Latency
//   - Raw input changes before edge t0 and then holds steady.
//   - stable updates at edge t0+1+DEBOUNCE_CYCLES.
//   - The new level is visible on the output from that edge onward.
//   - Default parameters: 5 edges after the first sampling edge.
//  Glitch rejection
//   - Any return of s2 to stable before the count completes clears the counter.
//   - A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never changes an output.
//  Pulse outputs
//   - Registered; asserted in exactly the cycle following the edge where stable flips.
//   - Deasserted on the next edge.
//   - key_press iff key_level goes 0->1; key_release iff 1->0.
//   - sw_change on either direction.
//  Bits are fully independent
//   - Simultaneous changes on several bits produce simultaneous pulses.
//   - No arbitration or priority between bits.
//  A press and a release pulse on the same bit are never high in the same cycle.
//  key_level is the inverse of the stable raw KEY value; sw_level equals the stable SW value.
// TESTING
//  T1 Reset: resetn=0 for 2 edges with KEY=4'hF, SW=0.
//     -> all outputs 0; no pulse for 10 further cycles.
//  T2 Clean press: KEY[0] 1->0, held.
//     -> key_level[0]=1 and key_press[0]=1 exactly 5 edges later (DEBOUNCE_CYCLES=4).
//     -> key_press[0] high for one cycle only; other bits remain 0.
//  T3 Bounce: KEY[1] low 2 cycles, high 1, low 2, then high.
//     -> key_level[1] and key_press[1] stay 0 throughout.
//  T4 Release: after T2, KEY[0] returns to 1.
//     -> key_release[0] 1-cycle pulse 5 edges later; key_level[0]=0.
//  T5 Switches: SW=10'h100 (SW[8]=1), held.
//     -> sw_level=10'h100 and sw_change=10'h100 for one cycle, 5 edges later.
//     -> SW 10'h100->10'h003 gives sw_change=10'h103 in a single cycle.
//  T6 Reset mid-debounce: KEY[2]=0 for 3 cycles, then resetn=0 for 1 edge, KEY[2] held low.
//     -> no pulse before reset.
//     -> key_press[2] occurs 5 edges after reset release.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronises and debounces raw push-buttons and slide switches, producing clean
// levels plus single-cycle press/release/change pulses for the downstream core.
module input_conditioner #(
    parameter int N_KEY           = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEY-1:0]  KEY,
    input  logic [N_SW-1:0]   SW,
    output logic [N_KEY-1:0]  key_level,
    output logic [N_KEY-1:0]  key_press,
    output logic [N_KEY-1:0]  key_release,
    output logic [N_SW-1:0]   sw_level,
    output logic [N_SW-1:0]   sw_change
);

    localparam int N = N_KEY + N_SW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw-polarity idle value: buttons released (high), switches low.
    localparam logic [N-1:0] RAW_IDLE = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

    logic [N-1:0]     w_raw;
    logic [N-1:0]     r_s1;
    logic [N-1:0]     r_s2;
    logic [N-1:0]     r_stable;
    logic [N-1:0]     r_set;
    logic [N-1:0]     r_clr;
    logic [CNT_W-1:0] r_cnt [N];

    assign w_raw = {SW, KEY};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1     <= RAW_IDLE;
            r_s2     <= RAW_IDLE;
            r_stable <= RAW_IDLE;
            r_set    <= '0;
            r_clr    <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1  <= w_raw;
            r_s2  <= r_s1;
            r_set <= '0;
            r_clr <= '0;
            for (int i = 0; i < N; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] < CNT_LAST) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    // Accept the new value; pulse direction is in active-level terms.
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                    r_set[i]    <= r_s2[i] ^ RAW_IDLE[i];
                    r_clr[i]    <= ~(r_s2[i] ^ RAW_IDLE[i]);
                end
            end
        end
    end

    assign key_level   = ~r_stable[N_KEY-1:0];
    assign key_press   = r_set[N_KEY-1:0];
    assign key_release = r_clr[N_KEY-1:0];
    assign sw_level    = r_stable[N-1:N_KEY];
    assign sw_change   = r_set[N-1:N_KEY] | r_clr[N-1:N_KEY];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a sliding-window debounce model.
module tb_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int DB = 4;
    localparam int NB = NK + NS;
    localparam logic [NB-1:0] IDLE = {{NS{1'b0}}, {NK{1'b1}}};

    logic          clk;
    logic          resetn;
    logic [NK-1:0] KEY;
    logic [NS-1:0] SW;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NS-1:0] sw_level;
    logic [NS-1:0] sw_change;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 0;

    input_conditioner #(
        .N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DB), .CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .KEY(KEY), .SW(SW),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .sw_level(sw_level), .sw_change(sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model: s2 is the raw input two edges late; a bit is accepted once the last
    // DB values of s2 (since reset) all disagree with the accepted value.
    logic [NB-1:0] m_s1, m_s2, m_stable, e_set, e_clr;
    logic [NB-1:0] win[$];

    always @(posedge clk) begin
        if (!resetn) begin
            m_s1     = IDLE;
            m_s2     = IDLE;
            m_stable = IDLE;
            e_set    = '0;
            e_clr    = '0;
            win.delete();
            started  = 1'b1;
        end else begin
            win.push_back(m_s2);
            if (win.size() > DB) void'(win.pop_front());
            e_set = '0;
            e_clr = '0;
            if (win.size() == DB) begin
                for (int b = 0; b < NB; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (win[j]) if (win[j][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[b] = ~m_stable[b];
                        if (m_stable[b] != IDLE[b]) e_set[b] = 1'b1;
                        else                        e_clr[b] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = {SW, KEY};
        end
    end

    logic [NB-1:0] e_level;
    assign e_level = m_stable ^ IDLE;

    always @(negedge clk) begin
        if (started) begin
            chk("m_key_level",   32'(key_level),   32'(e_level[NK-1:0]));
            chk("m_key_press",   32'(key_press),   32'(e_set[NK-1:0]));
            chk("m_key_release", 32'(key_release), 32'(e_clr[NK-1:0]));
            chk("m_sw_level",    32'(sw_level),    32'(e_level[NB-1:NK]));
            chk("m_sw_change",   32'(sw_change),   32'(e_set[NB-1:NK] | e_clr[NB-1:NK]));
        end
    end

    initial begin
        bit pat [13];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // T1 reset
        KEY = 4'hF; SW = '0; resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t1_outputs", 32'({key_level, key_press, key_release, sw_level, sw_change}), 32'd0);
            step();
        end

        // T2 clean press on KEY[0]
        KEY[0] = 1'b0;
        repeat (5) step();
        chk("t2_level_early", 32'(key_level), 32'h0);
        step();
        chk("t2_level", 32'(key_level), 32'h1);
        chk("t2_press", 32'(key_press), 32'h1);
        chk("t2_model_level", 32'(e_level[NK-1:0]), 32'h1);
        step();
        chk("t2_press_off", 32'(key_press), 32'h0);
        chk("t2_level_hold", 32'(key_level), 32'h1);

        // T3 bounce on KEY[1]
        for (int i = 0; i < 13; i++) begin
            KEY[1] = pat[i];
            step();
            chk("t3_level1", 32'(key_level[1]), 32'h0);
            chk("t3_press1", 32'(key_press[1]), 32'h0);
        end

        // T4 release KEY[0]
        KEY[0] = 1'b1;
        repeat (5) step();
        chk("t4_release_early", 32'(key_release), 32'h0);
        step();
        chk("t4_release", 32'(key_release), 32'h1);
        chk("t4_level", 32'(key_level), 32'h0);
        step();
        chk("t4_release_off", 32'(key_release), 32'h0);

        // T5 switches
        SW = 10'h100;
        repeat (6) step();
        chk("t5_sw_level", 32'(sw_level), 32'h100);
        chk("t5_sw_change", 32'(sw_change), 32'h100);
        step();
        chk("t5_sw_change_off", 32'(sw_change), 32'h0);
        SW = 10'h003;
        repeat (6) step();
        chk("t5_sw_change2", 32'(sw_change), 32'h103);
        chk("t5_sw_level2", 32'(sw_level), 32'h003);
        chk("t5_model_change2", 32'(e_set[NB-1:NK] | e_clr[NB-1:NK]), 32'h103);
        step();

        // T6 reset mid-debounce on KEY[2]
        KEY[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_press_pre", 32'(key_press), 32'h0);
        end
        resetn = 1'b0;
        step();
        chk("t6_reset_outputs", 32'({key_level, key_press, key_release}), 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_no_press_post", 32'(key_press), 32'h0);
        end
        step();
        chk("t6_press", 32'(key_press), 32'h4);
        chk("t6_level", 32'(key_level), 32'h4);

        // Randomized run: per-bit toggles with geometric hold times, occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
            end else begin
                resetn = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    for (int b = 0; b < NK; b++)
                        if ($urandom_range(0, 5) == 0) KEY[b] = ~KEY[b];
                    for (int b = 0; b < NS; b++)
                        if ($urandom_range(0, 5) == 0) SW[b] = ~SW[b];
                end
            end
            step();
        end
        resetn = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
